// File: rtl/fp_norm_round_pkg.sv
// Shared widths, stage-register layout and rounding helper for the post-add
// normalizer/rounder.
package fp_pkg;

    localparam int N_DEF   = 23;
    localparam int EXP_DEF = 8;
    localparam int EXP_MAX = (1 << EXP_DEF) - 1;
    localparam int LZW     = $clog2(N_DEF + 3);

    // S1 -> S2 register: raw operands plus the shift decision taken in S1
    typedef struct packed {
        logic                      sign;
        logic signed [EXP_DEF+1:0] exp;
        logic [N_DEF+1:0]          mant;
        logic                      g;
        logic                      st;
        logic                      zero;
        logic                      rshift;
        logic [LZW-1:0]            shamt;
    } s1_reg_t;

    function automatic logic rne_inc(input logic g, input logic l, input logic st);
        return g & (l | st);
    endfunction

endpackage

// File: rtl/fp_norm_round_if.sv
// Upstream (sum + guard/sticky) and downstream (packed result) handshake bundle.
interface fp_norm_round_if
    import fp_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int EXP = EXP_DEF
);
    logic           in_valid;
    logic           in_ready;
    logic           in_sign;
    logic [EXP-1:0] in_exp;
    logic [N+1:0]   in_mant;
    logic           in_R;
    logic           in_S;

    logic           out_valid;
    logic           out_ready;
    logic           out_sign;
    logic [EXP-1:0] out_exp;
    logic [N-1:0]   out_frac;
    logic           out_zero;
    logic           out_overflow;
    logic           out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_R, in_S, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac,
               out_zero, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_R, in_S, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac,
               out_zero, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_norm_round_lzc.sv
// Combinational leading-zero counter; count equals W when the vector is zero.
module fp_lzc #(
    parameter int W  = 25,
    parameter int CW = 5
) (
    input  logic [W-1:0]  i_vec,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    // Scan LSB to MSB so the most significant set bit wins
    always_comb begin
        o_count = CW'(W);
        o_zero  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_count = CW'(W - 1 - i);
                o_zero  = 1'b0;
            end else begin
                o_count = o_count;
                o_zero  = o_zero;
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage post-add normalizer with round-to-nearest-even. S1 decides the
// shift, S2 shifts, rounds and adjusts the exponent into the output registers.
module fp_norm_round
    import fp_pkg::*;
#(
    // The S1 register layout is sized from the package defaults
    parameter int N   = N_DEF,
    parameter int EXP = EXP_DEF
) (
    input logic           clk,
    input logic           rst,
    fp_norm_round_if.slave bus
);

    localparam logic signed [EXP+1:0] L_ONE  = (EXP+2)'(1);
    localparam logic signed [EXP+1:0] L_EMAX = (EXP+2)'(EXP_MAX);

    logic                  w_s1_adv;
    logic                  w_s2_adv;
    logic [N+1:0]          w_lz_vec;
    logic [LZW-1:0]        w_lz_cnt;
    logic                  w_lz_zero;
    s1_reg_t               w_s1_next;

    logic                  r_s1_valid;
    s1_reg_t               r_s1;

    logic [N+1:0]          w_lvec;
    logic [N:0]            w_m;
    logic                  w_g;
    logic                  w_st;
    logic signed [EXP+1:0] w_e_adj;
    logic signed [EXP+1:0] w_sh_ext;
    logic                  w_inc;
    logic [N:0]            w_fsum;
    logic signed [EXP+1:0] w_e_rnd;
    logic                  w_norm_zero;

    logic [EXP-1:0]        w_o_exp;
    logic [N-1:0]          w_o_frac;
    logic                  w_o_zero;
    logic                  w_o_ovf;
    logic                  w_o_unf;

    logic                  r_out_valid;
    logic                  r_out_sign;
    logic [EXP-1:0]        r_out_exp;
    logic [N-1:0]          r_out_frac;
    logic                  r_out_zero;
    logic                  r_out_ovf;
    logic                  r_out_unf;

    assign w_s2_adv     = ~r_out_valid | bus.out_ready;
    assign w_s1_adv     = ~r_s1_valid | w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    assign w_lz_vec = {bus.in_mant[N:0], bus.in_R};

    fp_lzc #(
        .W  (N + 2),
        .CW (LZW)
    ) u_lzc (
        .i_vec   (w_lz_vec),
        .o_count (w_lz_cnt),
        .o_zero  (w_lz_zero)
    );

    // S1 shift decision from the raw sum
    always_comb begin
        w_s1_next        = '0;
        w_s1_next.sign   = bus.in_sign;
        w_s1_next.exp    = $signed({2'b00, bus.in_exp});
        w_s1_next.mant   = bus.in_mant;
        w_s1_next.g      = bus.in_R;
        w_s1_next.st     = bus.in_S;
        w_s1_next.rshift = bus.in_mant[N+1];
        w_s1_next.zero   = ~bus.in_mant[N+1] & w_lz_zero;
        if (bus.in_mant[N+1] | bus.in_mant[N]) begin
            w_s1_next.shamt = '0;
        end else begin
            w_s1_next.shamt = w_lz_cnt;
        end
    end

    // S1 pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1       <= w_s1_next;
        end else begin
            r_s1_valid <= r_s1_valid;
            r_s1       <= r_s1;
        end
    end

    assign w_sh_ext = $signed({{(EXP+2-LZW){1'b0}}, r_s1.shamt});

    // S2 normalize: carry right-shift, or left-shift by the S1 count (zero when already normal)
    always_comb begin
        w_lvec = {r_s1.mant[N:0], r_s1.g} << r_s1.shamt;
        if (r_s1.rshift) begin
            w_m     = r_s1.mant[N+1:1];
            w_g     = r_s1.mant[0];
            w_st    = r_s1.g | r_s1.st;
            w_e_adj = $signed(r_s1.exp) + L_ONE;
        end else begin
            w_m     = w_lvec[N+1:1];
            w_g     = w_lvec[0];
            w_st    = r_s1.st;
            w_e_adj = $signed(r_s1.exp) - w_sh_ext;
        end
    end

    // Rounding only touches the fraction; a carry out of it bumps the exponent
    assign w_inc       = rne_inc(w_g, w_m[0], w_st);
    assign w_fsum      = {1'b0, w_m[N-1:0]} + {{N{1'b0}}, w_inc};
    assign w_e_rnd     = w_e_adj + $signed({{(EXP+1){1'b0}}, w_fsum[N]});
    assign w_norm_zero = r_s1.zero | ~w_m[N];

    // S2 result selection: zero, underflow flush, overflow saturation or normal
    always_comb begin
        w_o_exp  = '0;
        w_o_frac = '0;
        w_o_zero = 1'b0;
        w_o_ovf  = 1'b0;
        w_o_unf  = 1'b0;
        if (w_norm_zero) begin
            w_o_zero = 1'b1;
            w_o_unf  = r_s1.st;
        end else if (w_e_adj < L_ONE) begin
            w_o_zero = 1'b1;
            w_o_unf  = 1'b1;
        end else if (w_e_rnd >= L_EMAX) begin
            w_o_exp  = '1;
            w_o_ovf  = 1'b1;
        end else begin
            w_o_exp  = w_e_rnd[EXP-1:0];
            w_o_frac = w_fsum[N-1:0];
        end
    end

    // Output registers hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_frac  <= '0;
            r_out_zero  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            r_out_sign  <= r_s1.sign;
            r_out_exp   <= w_o_exp;
            r_out_frac  <= w_o_frac;
            r_out_zero  <= w_o_zero;
            r_out_ovf   <= w_o_ovf;
            r_out_unf   <= w_o_unf;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_sign  <= r_out_sign;
            r_out_exp   <= r_out_exp;
            r_out_frac  <= r_out_frac;
            r_out_zero  <= r_out_zero;
            r_out_ovf   <= r_out_ovf;
            r_out_unf   <= r_out_unf;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_sign      = r_out_sign;
    assign bus.out_exp       = r_out_exp;
    assign bus.out_frac      = r_out_frac;
    assign bus.out_zero      = r_out_zero;
    assign bus.out_overflow  = r_out_ovf;
    assign bus.out_underflow = r_out_unf;

endmodule
